// File: rtl/conv3x3_stream.sv
// rtl/conv3x3_stream.sv - streaming 3x3 convolution with two line buffers and 2-stage output pipe
// Optional: CONV_SATURATE_EN clamps results to the pixel range.
module conv3x3_stream #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [1:0]        ksel,
    output logic [ACC_W-1:0]  kresult,
    output logic              kres_valid,
    input  logic              kres_ready,
    output logic              frame_done
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [1:0] K_BLUR    = 2'b00;
    localparam logic [1:0] K_SHARPEN = 2'b01;
    localparam logic [1:0] K_EDGE    = 2'b10;
    localparam logic signed [ACC_W-1:0] DIV9    = ACC_W'(9);
    localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << DATA_W) - 1);

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [1:0]        kern;

    // Window columns: win_l oldest, win_m middle, win_r arriving; index 0 = top line.
    logic [DATA_W-1:0] win_l [3];
    logic [DATA_W-1:0] win_m [3];
    logic [DATA_W-1:0] win_r [3];

    logic adv, accept, win_full, win_last;
    logic signed [ACC_W-1:0] centre, edges, corners, sum;
    logic signed [ACC_W-1:0] s1_sum, s2_raw, s2_val;
    logic       s1_valid, s1_last;
    logic [1:0] s1_kern;

    function automatic logic signed [ACC_W-1:0] ext(input logic [DATA_W-1:0] p);
        return ACC_W'(p);
    endfunction

    assign adv       = !kres_valid || kres_ready;
    assign pix_ready = adv;
    assign accept    = pix_valid && adv;
    assign win_full  = (row >= ROW_W'(2)) && (col >= COL_W'(2));
    assign win_last  = (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));

    assign win_r[0] = lb1[col];
    assign win_r[1] = lb0[col];
    assign win_r[2] = pix_in;

    always_comb begin
        centre  = ext(win_m[1]);
        edges   = ext(win_m[0]) + ext(win_l[1]) + ext(win_r[1]) + ext(win_m[2]);
        corners = ext(win_l[0]) + ext(win_r[0]) + ext(win_l[2]) + ext(win_r[2]);
        case (kern)
            K_BLUR:    sum = centre + edges + corners;
            K_SHARPEN: sum = (centre <<< 2) + centre - edges;
            K_EDGE:    sum = (centre <<< 3) + centre - edges - corners;
            default:   sum = centre;
        endcase
    end

    always_comb begin
        s2_raw = (s1_kern == K_BLUR) ? (s1_sum / DIV9) : s1_sum;
`ifdef CONV_SATURATE_EN
        if (s2_raw[ACC_W-1])
            s2_val = '0;
        else if (s2_raw > PIX_MAX)
            s2_val = PIX_MAX;
        else
            s2_val = s2_raw;
`else
        s2_val = s2_raw;
`endif
    end

    // Storage with don't-care reset contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col] <= lb0[col];
            lb0[col] <= pix_in;
            for (int i = 0; i < 3; i++) begin
                win_l[i] <= win_m[i];
                win_m[i] <= win_r[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            kern       <= K_BLUR;
            s1_sum     <= '0;
            s1_valid   <= 1'b0;
            s1_last    <= 1'b0;
            s1_kern    <= K_BLUR;
            kresult    <= '0;
            kres_valid <= 1'b0;
            frame_done <= 1'b0;
        end else if (adv) begin
            s1_valid <= accept && win_full;
            s1_last  <= win_last;
            s1_sum   <= sum;
            s1_kern  <= kern;
            if (accept) begin
                if (row == '0 && col == '0)
                    kern <= ksel;
                if (col == COL_W'(IMG_W - 1)) begin
                    col <= '0;
                    row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            kres_valid <= s1_valid;
            frame_done <= s1_valid && s1_last;
            if (s1_valid)
                kresult <= s2_val;
        end
    end
endmodule

// File: tb/tb_conv3x3_stream.sv
// tb/tb_conv3x3_stream.sv - directed self-checking bench for conv3x3_stream
module tb_conv3x3_stream;
    localparam int W    = 8;
    localparam int H    = 6;
    localparam int NRES = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  pix_in;
    logic        pix_valid, pix_ready;
    logic [1:0]  ksel;
    logic [15:0] kresult;
    logic        kres_valid, kres_ready, frame_done;

    int img [H][W];
    int got [64];
    bit fd  [64];
    int nres;
    int n_pass  = 0;
    int n_total = 0;
    bit ready_bad, stable_bad;
    bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    conv3x3_stream #(.DATA_W(8), .ACC_W(16), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .ksel(ksel), .kresult(kresult), .kres_valid(kres_valid), .kres_ready(kres_ready),
        .frame_done(frame_done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int ref_conv(input int r, input int c, input int ks);
        int ctr, e, k, s;
        ctr = img[r][c];
        e   = img[r-1][c] + img[r+1][c] + img[r][c-1] + img[r][c+1];
        k   = img[r-1][c-1] + img[r-1][c+1] + img[r+1][c-1] + img[r+1][c+1];
        case (ks)
            0:       s = (ctr + e + k) / 9;
            1:       s = 5 * ctr - e;
            2:       s = 9 * ctr - e - k;
            default: s = ctr;
        endcase
`ifdef CONV_SATURATE_EN
        if (s < 0) s = 0;
        if (s > 255) s = 255;
`endif
        return s;
    endfunction

    function automatic int idx(input int r, input int c);
        return (r - 1) * (W - 2) + (c - 1);
    endfunction

    task automatic fill(input int v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    // ksel is driven to the wrong kernel after pixel 0 to show it is ignored mid-frame.
    task automatic run_frame(input int ks, input bit bp, input int npix, input bit drain_en);
        int p = 0, cyc = 0, drain = 0, last = 0;
        bit stalled = 0;
        nres = 0; ready_bad = 0; stable_bad = 0;
        while ((p < npix || (drain_en && drain < 8)) && cyc < 3000) begin
            @(negedge clk);
            pix_valid  = (p < npix);
            pix_in     = pix_valid ? 8'(img[p / W][p % W]) : 8'h00;
            ksel       = (p == 0) ? 2'(ks) : ~2'(ks);
            kres_ready = (bp && p < npix) ? (bp_pat[cyc % 4] ^ ($urandom_range(0, 5) == 0)) : 1'b1;
            #1;
            if (pix_ready !== (!kres_valid || kres_ready)) ready_bad = 1;
            if (stalled && (!kres_valid || int'($signed(kresult)) != last)) stable_bad = 1;
            stalled = kres_valid && !kres_ready;
            last    = int'($signed(kresult));
            if (kres_valid && kres_ready) begin
                if (nres < 64) begin
                    got[nres] = last;
                    fd[nres]  = frame_done;
                end
                nres++;
            end
            if (pix_valid && pix_ready) p++;
            if (p >= npix) drain++;
            cyc++;
        end
        check("pixels_accepted_in_budget", p, npix);
        @(negedge clk);
        pix_valid  = 1'b0;
        kres_ready = 1'b1;
    endtask

    task automatic check_frame(input int ks, input string tag);
        int nfd = 0;
        check({tag, "_count"}, nres, NRES);
        for (int i = 0; i < NRES && i < nres; i++) begin
            check($sformatf("%s_res%0d", tag, i), got[i], ref_conv(1 + i / (W - 2), 1 + i % (W - 2), ks));
            nfd += int'(fd[i]);
        end
        check({tag, "_fd_count"}, nfd, 1);
        check({tag, "_fd_last"}, int'(fd[NRES-1]), 1);
    endtask

    initial begin
        rst = 1'b1; pix_valid = 1'b0; pix_in = '0; ksel = '0; kres_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_kres_valid", int'(kres_valid), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_kresult", int'(kresult), 0);
        check("rst_pix_ready", int'(pix_ready), 1);
        rst = 1'b0;

        fill(11);
        run_frame(0, 0, W * H, 1);
        check_frame(0, "blur_flat");
        check("blur_flat_val", got[5], 11);

        fill(11); img[3][3] = 15;
        run_frame(1, 0, W * H, 1);
        check_frame(1, "sharpen");
        check("sharpen_centre", got[idx(3, 3)], 31);
        check("sharpen_edge", got[idx(2, 3)], 7);
        check("sharpen_corner", got[idx(2, 2)], 11);

        fill(11); img[3][3] = 22;
        run_frame(2, 0, W * H, 1);
        check_frame(2, "edge");
        check("edge_centre", got[idx(3, 3)], 110);
        check("edge_corner", got[idx(2, 2)], 0);
        check("edge_side", got[idx(2, 3)], 0);

        fill(255); img[2][2] = 0;
        run_frame(1, 0, W * H, 1);
        check_frame(1, "sharp255");
`ifdef CONV_SATURATE_EN
        check("sharp255_centre", got[idx(2, 2)], 0);
        check("sharp255_side", got[idx(1, 2)], 255);
`else
        check("sharp255_centre", got[idx(2, 2)], -1020);
        check("sharp255_side", got[idx(1, 2)], 510);
`endif
        check("sharp255_corner", got[idx(1, 1)], 255);

        fill(11);
        run_frame(0, 1, W * H, 1);
        check_frame(0, "backpressure");
        check("bp_pix_ready_tracks_adv", int'(ready_bad), 0);
        check("bp_kresult_stable", int'(stable_bad), 0);

        fill(33);
        run_frame(2, 0, 20, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_kres_valid", int'(kres_valid), 0);
        check("midrst_frame_done", int'(frame_done), 0);
        check("midrst_kresult", int'(kresult), 0);
        rst = 1'b0;

        fill(22);
        run_frame(3, 0, W * H, 1);
        check_frame(3, "ident_after_rst");
        check("ident_val", got[NRES-1], 22);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
